vga_framebuffer_arbiter: RTL and testbench
==========================================

# vga_framebuffer_arbiter

Shares one single-ported framebuffer memory (off-chip SRAM/SDRAM controller, Avalon-MM slave) between the VGA prefetch read port (`pxl_*`) and the pixel-processing port (`pro_*`). Prefetch traffic has priority, and a starvation guard guarantees processing-side progress. Read responses from a pipelined, variable-latency memory are routed back to the issuing port through an in-order tag FIFO. The block sits in the `sys_clk` domain between the framebuffer VGA controller and the memory controller.

## Interface
- `AVN_AW`, 18, Avalon address width
- `AVN_DW`, 16, Avalon data width
- `MAX_OUTSTANDING`, 4, maximum in-flight reads (power of 2, ≥2)
- `PXL_MAX_GRANT`, 8, consecutive pxl grants allowed while pro is waiting

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: synchronous reset, active-low.
- `pxl_avn_read` in 1; `pxl_avn_address` in AVN_AW; `pxl_avn_readdata` out AVN_DW; `pxl_avn_readdatavalid` out 1; `pxl_avn_waitrequest` out 1. Prefetch port, read-only.
- `pro_avn_read`, `pro_avn_write` in 1; `pro_avn_address` in AVN_AW; `pro_avn_writedata` in AVN_DW; `pro_avn_byteenable` in AVN_DW/8; `pro_avn_readdata` out AVN_DW; `pro_avn_readdatavalid` out 1; `pro_avn_waitrequest` out 1. Processing port.
- `mem_avn_read`, `mem_avn_write` out 1; `mem_avn_address` out AVN_AW; `mem_avn_writedata` out AVN_DW; `mem_avn_byteenable` out AVN_DW/8; `mem_avn_readdata` in AVN_DW; `mem_avn_readdatavalid` in 1; `mem_avn_waitrequest` in 1. Memory master.
- `err_orphan` out 1: sticky flag; a response arrived with no read outstanding.

## Operation
- A port is requesting when it asserts read, or write on pro. Both requesters hold a request stable until it is accepted, per Avalon-MM.
- Grant decision (combinational, evaluated each cycle when unlocked):
  - Only one port requesting: grant that port.
  - Both requesting: grant pxl, unless `starve_cnt == PXL_MAX_GRANT`, in which case grant pro.
- Lock: if the granted request is not accepted (`mem_avn_waitrequest`=1 or the read is blocked by credit), latch `lock=1` with `owner`. Grant stays with `owner` until that request is accepted. Lock clears in the acceptance cycle.
- Mux: the granted port drives all `mem_avn_*` request signals. When pxl is granted: `mem_avn_write`=0, `mem_avn_byteenable`=all ones, `mem_avn_writedata`=0. When there is no grant, `mem_avn_read`/`mem_avn_write`=0.
- Waitrequest:
  - Non-granted requesting port: 1.
  - Granted port: `mem_avn_waitrequest` OR (read AND `outstanding == MAX_OUTSTANDING`).
  - Idle port: 1.
- Credit: when `outstanding == MAX_OUTSTANDING`, a read is not presented to memory (`mem_avn_read`=0). A pop in the same cycle does not free a credit until the next cycle.
- Tag FIFO (depth `MAX_OUTSTANDING`, 1-bit ID: 0=pxl, 1=pro):
  - Push on every accepted read.
  - Pop on `mem_avn_readdatavalid`.
  - Writes are not tagged.
  - `outstanding` = FIFO count. Simultaneous push and pop leaves the count unchanged.
- Response routing:
  - `mem_avn_readdata` is broadcast to both readdata outputs.
  - `*_readdatavalid` = `mem_avn_readdatavalid` AND (head ID matches).
  - `mem_avn_readdatavalid` with an empty FIFO: drop, no valid raised, set `err_orphan`.
- `starve_cnt` (width clog2(PXL_MAX_GRANT)+1):
  - +1 on each accepted pxl request while pro is requesting.
  - Cleared on an accepted pro request, or when pro is not requesting.
  - Saturates at `PXL_MAX_GRANT`.

## Timing
- Grant, mux and waitrequest are combinational: a request is accepted in the same cycle it is presented if memory is not stalling. Zero added request latency.
- Response routing is combinational: `*_readdatavalid` is asserted in the same cycle as `mem_avn_readdatavalid`.
- Sustained throughput is one transaction per cycle. Back-to-back alternation between ports needs no bubble cycle.
- Reset (`sys_rst_n`=0, sampled on the clock edge), in the reset cycle and after:
  - `lock`=0, `starve_cnt`=0, tag FIFO empty, `err_orphan`=0.
  - While `sys_rst_n`=0: `mem_avn_read`/`mem_avn_write`=0, both waitrequests=1, both readdatavalids=0.
- Reset mid-operation drops all outstanding reads. Responses arriving after reset deasserts are orphans and set `err_orphan`. The system must reset the memory controller together with this block.

## Test plan
- pxl streams reads to addresses 0..15, pro idle, memory latency 3 with no waitrequest: 16 accepted back-to-back, 16 pxl valids in order, pro valid never asserted.
- Both ports read continuously, `PXL_MAX_GRANT`=8: grant pattern is 8 pxl, 1 pro, repeating. pro sees its valid every 9th response.
- pro write (addr 0x100, data 0xABCD, be 2'b10) held while `mem_avn_waitrequest`=1 for 3 cycles, with pxl requesting in the meantime: grant stays pro (lock) for 4 cycles. Memory sees a stable write. pxl waitrequest=1 throughout.
- Memory latency 10, `MAX_OUTSTANDING`=4: the 5th read is held with waitrequest=1 and `mem_avn_read`=0 until the first response, then accepted the cycle after the pop.
- Interleaved tags pxl, pro, pro, pxl with responses D0..D3: valids route pxl, pro, pro, pxl in the same cycle as each response.
- `sys_rst_n`=0 for 1 cycle with 2 reads outstanding, then 2 responses arrive: both dropped, `err_orphan`=1 and it stays set until the next reset.

Source files
------------

// File: rtl/vga_framebuffer_arbiter_if.sv
// Avalon-MM bus bundle shared by the prefetch, processing and memory sides
// of the framebuffer arbiter.
interface vga_framebuffer_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic            read;
    logic            write;
    logic [AW-1:0]   address;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport master (
        output read, write, address, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  read, write, address, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/vga_framebuffer_arbiter.sv
// Two-port framebuffer arbiter: VGA prefetch has priority, a starvation guard
// lets processing through, and an in-order tag FIFO routes read responses.
module vga_framebuffer_arbiter #(
    parameter int AVN_AW          = 18,
    parameter int AVN_DW          = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PXL_MAX_GRANT   = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    vga_framebuffer_arbiter_if.slave  pxl,
    vga_framebuffer_arbiter_if.slave  pro,
    vga_framebuffer_arbiter_if.master mem,
    output logic                      err_orphan
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(PXL_MAX_GRANT) + 1;
    localparam logic [CW-1:0] CREDITS    = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(PXL_MAX_GRANT);

    typedef enum logic {
        PORT_PXL = 1'b0,
        PORT_PRO = 1'b1
    } port_t;

    logic          lock;
    port_t         owner;
    logic [SW-1:0] starve_cnt;
    logic          tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic  pxl_req;
    logic  pro_req;
    logic  gnt_valid;
    port_t gnt;
    logic  gnt_read;
    logic  gnt_write;
    logic  credit_full;
    logic  stall;
    logic  accept;
    logic  pending;
    logic  push;
    logic  pop;
    logic  fifo_empty;
    logic  head_tag;

    always_comb begin
        pxl_req     = pxl.read;
        pro_req     = pro.read | pro.write;
        credit_full = (count == CREDITS);
        fifo_empty  = (count == '0);
        head_tag    = tag_mem[rd_ptr];
        gnt         = PORT_PXL;
        gnt_valid   = 1'b0;

        if (!sys_rst_n) begin
            gnt_valid = 1'b0;
        end else if (lock) begin
            gnt       = owner;
            gnt_valid = 1'b1;
        end else if (pxl_req && pro_req) begin
            gnt       = (starve_cnt == STARVE_MAX) ? PORT_PRO : PORT_PXL;
            gnt_valid = 1'b1;
        end else if (pro_req) begin
            gnt       = PORT_PRO;
            gnt_valid = 1'b1;
        end else if (pxl_req) begin
            gnt       = PORT_PXL;
            gnt_valid = 1'b1;
        end

        gnt_read  = gnt_valid && ((gnt == PORT_PRO) ? pro.read : pxl.read);
        gnt_write = gnt_valid && (gnt == PORT_PRO) && pro.write;

        // A read with no credit left is hidden from memory and held as a stall.
        mem.read       = gnt_read && !credit_full;
        mem.write      = gnt_write;
        mem.address    = (gnt == PORT_PRO) ? pro.address : pxl.address;
        mem.writedata  = (gnt == PORT_PRO) ? pro.writedata : '0;
        mem.byteenable = (gnt == PORT_PRO) ? pro.byteenable : '1;

        stall   = mem.waitrequest || (gnt_read && credit_full);
        accept  = (gnt_read || gnt_write) && !stall;
        pending = (gnt_read || gnt_write) && stall;
        push    = gnt_read && !stall;
        pop     = sys_rst_n && mem.readdatavalid && !fifo_empty;

        pxl.waitrequest = !(gnt_valid && (gnt == PORT_PXL)) || stall;
        pro.waitrequest = !(gnt_valid && (gnt == PORT_PRO)) || stall;

        pxl.readdata      = mem.readdata;
        pro.readdata      = mem.readdata;
        pxl.readdatavalid = pop && !head_tag;
        pro.readdatavalid = pop && head_tag;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lock       <= 1'b0;
            owner      <= PORT_PXL;
            starve_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            lock <= pending;
            if (pending) begin
                owner <= gnt;
            end

            if (!pro_req) begin
                starve_cnt <= '0;
            end else if (accept && (gnt == PORT_PRO)) begin
                starve_cnt <= '0;
            end else if (accept && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Responses with nothing outstanding are dropped and flagged.
            if (mem.readdatavalid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= (gnt == PORT_PRO);
        end
    end
endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// Scoreboard bench for vga_framebuffer_arbiter; the memory model returns
// address + 0x1000 as read data after a configurable latency.
module tb_vga_framebuffer_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic err_orphan;

    vga_framebuffer_arbiter_if #(.AW(AW), .DW(DW)) pxl ();
    vga_framebuffer_arbiter_if #(.AW(AW), .DW(DW)) pro ();
    vga_framebuffer_arbiter_if #(.AW(AW), .DW(DW)) mem ();

    vga_framebuffer_arbiter #(
        .AVN_AW(AW), .AVN_DW(DW), .MAX_OUTSTANDING(4), .PXL_MAX_GRANT(8)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .pxl(pxl), .pro(pro), .mem(mem),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
    } pro_req_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    logic [AW-1:0] pxl_q[$];
    pro_req_t      pro_q[$];
    logic [DW-1:0] exp_pxl[$];
    logic [DW-1:0] exp_pro[$];
    resp_t         pend[$];
    bit            acc_port[$];
    int            acc_cyc[$];

    int checks = 0;
    int failures = 0;
    int lat = 3;
    int stall_left = 0;
    int cyc = 0;
    int pxl_stall = 0;
    int stall_bad = 0;
    int pxl_vcnt = 0;
    int pro_vcnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit to_pro, input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [1:0] be,
                                 input logic [DW-1:0] exp_data);
        pro_req_t r;
        if (!to_pro) begin
            pxl_q.push_back(addr);
            exp_pxl.push_back(exp_data);
        end else begin
            r.wr = wr; r.addr = addr; r.data = wdata; r.be = be;
            pro_q.push_back(r);
            if (!wr) exp_pro.push_back(exp_data);
        end
    endtask

    function automatic int busyCount();
        return pxl_q.size() + pro_q.size() + exp_pxl.size() + exp_pro.size() + pend.size();
    endfunction

    task automatic waitDrain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (busyCount() == 0) break;
            @(posedge clk); #1;
        end
        checkOutput("drain_timeout", busyCount(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        acc_port.delete();
        acc_cyc.delete();
        pxl_vcnt = 0;
        pro_vcnt = 0;
        pxl_stall = 0;
        stall_bad = 0;
    endtask

    // Prefetch requester: holds the head request until it sees waitrequest low.
    initial begin
        pxl.read = 1'b0; pxl.write = 1'b0; pxl.address = '0;
        pxl.writedata = '0; pxl.byteenable = '0;
        forever begin
            @(negedge clk);
            if (pxl_q.size() > 0) begin
                pxl.read = 1'b1;
                pxl.address = pxl_q[0];
            end else begin
                pxl.read = 1'b0;
            end
            #2;
            if (pxl.read && !pxl.waitrequest) void'(pxl_q.pop_front());
        end
    end

    initial begin
        pro.read = 1'b0; pro.write = 1'b0; pro.address = '0;
        pro.writedata = '0; pro.byteenable = '0;
        forever begin
            @(negedge clk);
            if (pro_q.size() > 0) begin
                pro.read       = !pro_q[0].wr;
                pro.write      = pro_q[0].wr;
                pro.address    = pro_q[0].addr;
                pro.writedata  = pro_q[0].data;
                pro.byteenable = pro_q[0].be;
            end else begin
                pro.read  = 1'b0;
                pro.write = 1'b0;
            end
            #2;
            if ((pro.read || pro.write) && !pro.waitrequest) void'(pro_q.pop_front());
        end
    end

    // Pipelined memory: responses leave in acceptance order after lat cycles.
    initial begin
        mem.readdatavalid = 1'b0; mem.readdata = '0; mem.waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem.waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            mem.readdatavalid = 1'b0;
            mem.readdata = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem.readdatavalid = 1'b1;
                mem.readdata = pend[0].data;
                void'(pend.pop_front());
            end
        end
    end

    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && mem.read && !mem.waitrequest) begin
                r.due = cyc + lat;
                r.data = mem.address[15:0] + 16'h1000;
                pend.push_back(r);
            end
            if (pxl.read && !pxl.waitrequest) begin
                acc_port.push_back(1'b0); acc_cyc.push_back(cyc);
            end
            if ((pro.read || pro.write) && !pro.waitrequest) begin
                acc_port.push_back(1'b1); acc_cyc.push_back(cyc);
            end
            if (pxl.read && pxl.waitrequest) begin
                pxl_stall++;
                if (mem.read) stall_bad++;
            end
        end
    end

    // Monitor: every valid pops the owning port's expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (pxl.readdatavalid) begin
                pxl_vcnt++;
                if (exp_pxl.size() == 0) checkOutput("pxl_unexpected_valid", pxl.readdatavalid, 1'b0);
                else checkOutput("pxl_rdata", pxl.readdata, exp_pxl.pop_front());
            end
            if (pro.readdatavalid) begin
                pro_vcnt++;
                if (exp_pro.size() == 0) checkOutput("pro_unexpected_valid", pro.readdatavalid, 1'b0);
                else checkOutput("pro_rdata", pro.readdata, exp_pro.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 18'(i), '0, '0, 16'h1000 + 16'(i));
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        checkOutput("rst_mem_req", {mem.read, mem.write}, 2'b00);
        checkOutput("rst_pxl_wait", pxl.waitrequest, 1'b1);
        checkOutput("rst_pro_wait", pro.waitrequest, 1'b1);
        checkOutput("rst_valids", {pxl.readdatavalid, pro.readdatavalid}, 2'b00);
        checkOutput("rst_orphan", err_orphan, 1'b0);
        @(posedge clk); #1;
        clearLogs();
        rst_n = 1'b1;

        $display("[TB] pxl stream of 16 reads");
        waitDrain(200);
        checkOutput("t1_accepts", acc_port.size(), 16);
        if (acc_cyc.size() == 16) checkOutput("t1_span", acc_cyc[15] - acc_cyc[0], 15);
        checkOutput("t1_pxl_valids", pxl_vcnt, 16);
        checkOutput("t1_pro_valids", pro_vcnt, 0);

        $display("[TB] both ports streaming");
        clearLogs();
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 18'h200 + 18'(i), '0, '0, 16'h1200 + 16'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 18'h300 + 18'(i), '0, '0, 16'h1300 + 16'(i));
        waitDrain(300);
        checkOutput("t2_accepts", acc_port.size(), 21);
        if (acc_port.size() == 21) begin
            for (int k = 0; k < 21; k++)
                checkOutput($sformatf("t2_grant_%0d", k), acc_port[k], (k == 8 || k == 17 || k == 20));
            checkOutput("t2_span", acc_cyc[20] - acc_cyc[0], 20);
        end
        checkOutput("t2_pro_valids", pro_vcnt, 3);

        $display("[TB] locked pro write under memory stall");
        clearLogs();
        stall_left = 3;
        applyStimulus(1, 1, 18'h100, 16'hABCD, 2'b10, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            checkOutput("t3_mem_ctl", {mem.write, mem.read, mem.byteenable}, 4'b1010);
            checkOutput("t3_mem_addr", mem.address, 18'h100);
            checkOutput("t3_mem_wdata", mem.writedata, 16'hABCD);
            checkOutput("t3_pxl_wait", pxl.waitrequest, 1'b1);
            checkOutput("t3_pro_wait", pro.waitrequest, (i < 3));
            if (i == 0) applyStimulus(0, 0, 18'h20, '0, '0, 16'h1020);
        end
        waitDrain(100);
        checkOutput("t3_accepts", acc_port.size(), 2);
        if (acc_port.size() == 2) checkOutput("t3_order", {acc_port[0], acc_port[1]}, 2'b10);

        $display("[TB] credit limit with latency 10");
        clearLogs();
        lat = 10;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 18'h40 + 18'(i), '0, '0, 16'h1040 + 16'(i));
        waitDrain(200);
        checkOutput("t4_accepts", acc_cyc.size(), 5);
        if (acc_cyc.size() == 5) checkOutput("t4_fifth_gap", acc_cyc[4] - acc_cyc[0], 11);
        checkOutput("t4_stall_cycles", pxl_stall, 7);
        checkOutput("t4_read_while_held", stall_bad, 0);
        lat = 3;

        $display("[TB] interleaved tags");
        clearLogs();
        applyStimulus(0, 0, 18'h80, '0, '0, 16'h1080);
        @(posedge clk); #1;
        applyStimulus(1, 0, 18'h90, '0, '0, 16'h1090);
        @(posedge clk); #1;
        applyStimulus(1, 0, 18'h91, '0, '0, 16'h1091);
        @(posedge clk); #1;
        applyStimulus(0, 0, 18'h81, '0, '0, 16'h1081);
        waitDrain(100);
        checkOutput("t5_accepts", acc_port.size(), 4);
        if (acc_port.size() == 4)
            checkOutput("t5_order", {acc_port[0], acc_port[1], acc_port[2], acc_port[3]}, 4'b0110);
        checkOutput("t5_pxl_valids", pxl_vcnt, 2);
        checkOutput("t5_pro_valids", pro_vcnt, 2);

        $display("[TB] reset with reads outstanding");
        clearLogs();
        lat = 10;
        applyStimulus(0, 0, 18'hC0, '0, '0, 16'h10C0);
        applyStimulus(0, 0, 18'hC1, '0, '0, 16'h10C1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_accepts", acc_port.size(), 2);
        rst_n = 1'b0;
        exp_pxl.delete();
        @(negedge clk); #2;
        checkOutput("t6_rst_mem_req", {mem.read, mem.write}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #2;
        checkOutput("t6_orphan_before", err_orphan, 1'b0);
        waitDrain(100);
        checkOutput("t6_orphan_set", err_orphan, 1'b1);
        checkOutput("t6_dropped_valids", pxl_vcnt + pro_vcnt, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_orphan_sticky", err_orphan, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("t6_orphan_cleared", err_orphan, 1'b0);
        lat = 3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
